sprite_line_fetch: RTL and testbench
====================================

Name: sprite_line_fetch

Overview:
- Per-scanline sprite fetch engine. Sits directly upstream of the sprite pattern table stage.
- Reads up to 8 selected sprites (Y, tile, attr, X) from secondary OAM.
- Computes each sprite's row offset and drives tile_num/yoffset into the pattern table.
- Captures the returned line0/line1 bit-planes, applies horizontal flip, and writes one complete slot per sprite into the sprite shifter bank for the next scanline.

Parameters:
- FETCH_LAT, 2, cycles from tile_num/yoffset stable to line0/line1 valid at the rising edge (1 for BRAM, 1 for negedge output register).
- NUM_SLOTS, 8, sprite slots per scanline; fixed at 8 in this revision.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous reset, active high.
- start  in  1  one-cycle pulse: begin fetch for scanline.
- scanline  in  8  target scanline, sampled on the start cycle.
- sprite_cnt  in  4  number of valid sprites in secondary OAM, sampled on start; values >8 clamp to 8.
- oam_addr  out  5  secondary OAM byte address {slot[2:0], byte[1:0]}.
- oam_data  in  8  secondary OAM read data, 1-cycle latency.
- tile_num  out  8  to pattern table.
- yoffset  out  3  to pattern table.
- line0  in  8  pattern low plane from pattern table.
- line1  in  8  pattern high plane from pattern table.
- slot_we  out  1  slot write strobe, one cycle per slot.
- slot_idx  out  3  slot being written.
- slot_lo  out  8  low plane, flip applied.
- slot_hi  out  8  high plane, flip applied.
- slot_attr  out  8  attribute byte.
- slot_x  out  8  X position.
- busy  out  1  high while fetching.
- done  out  1  one-cycle pulse after the last slot write.

Behaviour:
- Reset values:
  - oam_addr=0, tile_num=0, yoffset=0.
  - slot_we=0, slot_idx=0, slot_lo=0, slot_hi=0, slot_attr=0, slot_x=0.
  - busy=0, done=0. State IDLE.
- OAM byte order: 0=Y, 1=tile, 2=attr, 3=X.
- attr bit7 = vflip, bit6 = hflip; other bits are passed through untouched.
- States and transitions:
  - IDLE: start=1 → latch scanline and clamped count, set slot counter to 0, busy=1. If count=0 go to FILL, else READ.
  - READ: issue oam_addr for bytes 0..3 on 4 consecutive cycles; capture data one cycle after each address (5 cycles total). Then go to CALC.
  - CALC (1 cycle): diff = scanline − Y, 8-bit modulo.
    - diff<8: row = vflip ? 7−diff[2:0] : diff[2:0]; drive tile_num=tile, yoffset=row; go to WAIT.
    - diff≥8 (out of range, including wrap when Y>scanline): mark transparent and skip directly to WRITE.
  - WAIT: hold tile_num/yoffset stable for FETCH_LAT cycles, then go to WRITE.
  - WRITE (1 cycle): slot_we=1, slot_idx=slot counter.
    - slot_lo/slot_hi = line0/line1 as sampled at this edge, bit-reversed when hflip=1.
    - If transparent: lo=hi=0.
    - slot_attr, slot_x come from OAM.
    - Increment slot counter. If counter < count go to READ, else if count < 8 go to FILL, else go to FIN.
  - FILL: one write per cycle for each remaining slot up to 7: lo=hi=0, attr=0, x=8'hFF. After slot 7 go to FIN.
  - FIN: done=1 for one cycle, busy=0, return to IDLE.
- Timing:
  - A valid sprite costs 5+1+FETCH_LAT+1 = 9 cycles by default.
  - An out-of-range sprite costs 7 cycles.
  - Each empty slot costs 1 cycle.
  - Exactly 8 slot_we pulses occur per start, with slot_idx 0..7 in order.
- tile_num/yoffset keep their last value outside WAIT; only values stable for FETCH_LAT cycles are consumed.
- start while busy=1 is ignored and does not restart.
- rst mid-operation: return to IDLE next edge, with no further slot_we and no done pulse.
- slot_we and done are never asserted in the same cycle.

Test Plan:
- rst held 3 cycles, then released → all outputs 0, busy=0; start with sprite_cnt=0 → 8 writes idx 0..7, each with lo=hi=0, x=FF; done on the cycle after idx 7; busy 1→0.
- One sprite {Y=10, tile=0x21, attr=0x00, X=40}, scanline=13 → tile_num=0x21, yoffset=3 held 2 cycles; slot 0 gets pattern-model line0/line1 unchanged, x=40, attr=0; slots 1–7 empty.
- Same sprite with attr=0xC0 and model line0=0x01, line1=0x80 → yoffset=4; slot_lo=0x80, slot_hi=0x01, attr=0xC0.
- Out of range: Y=200, scanline=5 (wrap) and Y=5, scanline=13 → both slots transparent, x from OAM, and no WAIT cycles (7-cycle slot).
- sprite_cnt=12, 8 valid sprites → clamps to 8, exactly 8 writes, no FILL; start pulsed mid-fetch is ignored; done exactly once.
- rst asserted during WAIT of slot 3 → no further slot_we, no done, busy=0 next cycle; a new start then completes normally.

Source files
------------

// File: rtl/sprite_line_fetch.sv
// Per-scanline sprite fetch: reads up to 8 sprites from secondary OAM, fetches
// their pattern rows and writes one shifter slot per sprite for the next line.
module sprite_line_fetch #(
  parameter int FETCH_LAT = 2,
  parameter int NUM_SLOTS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] scanline,
  input  logic [3:0] sprite_cnt,
  output logic [4:0] oam_addr,
  input  logic [7:0] oam_data,
  output logic [7:0] tile_num,
  output logic [2:0] yoffset,
  input  logic [7:0] line0,
  input  logic [7:0] line1,
  output logic       slot_we,
  output logic [2:0] slot_idx,
  output logic [7:0] slot_lo,
  output logic [7:0] slot_hi,
  output logic [7:0] slot_attr,
  output logic [7:0] slot_x,
  output logic       busy,
  output logic       done,
  output logic [2:0] state_dbg
);

  // Protocol: start is a one-cycle request accepted only in IDLE (ignored while
  // busy). slot_we is a push-only strobe with no backpressure: the shifter bank
  // must take slot_idx/slot_lo/slot_hi/slot_attr/slot_x in every cycle it is high.
  // Exactly 8 strobes follow an accepted start, then done pulses once.

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CALC,
    S_WAIT,
    S_WRITE,
    S_FILL,
    S_FIN
  } state_t;

  localparam logic [3:0] MAX_CNT  = 4'(NUM_SLOTS);
  localparam logic [3:0] LAT_LAST = 4'(FETCH_LAT - 1);

  state_t      state;
  state_t      state_n;

  logic [7:0]  scan_q;
  logic [3:0]  count_q;
  logic [2:0]  slot_cnt;
  logic [2:0]  rd_cnt;
  logic [3:0]  wait_cnt;
  logic [7:0]  y_q;
  logic [7:0]  tile_q;
  logic [7:0]  attr_q;
  logic [7:0]  x_q;

  logic [7:0]  diff;
  logic        in_range;
  logic [2:0]  row;
  logic [3:0]  slot_nxt;
  logic [3:0]  clamp_cnt;
  logic        load_line;
  logic        load_trans;
  logic        load_fill;

  function automatic logic [7:0] bit_rev(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = v[7-i];
    end
    return r;
  endfunction

  // A sprite above the line wraps to a large diff, so one compare covers both cases.
  assign diff      = scan_q - y_q;
  assign in_range  = (diff[7:3] == 5'd0);
  assign row       = attr_q[7] ? ~diff[2:0] : diff[2:0];
  assign slot_nxt  = {1'b0, slot_cnt} + 4'd1;
  assign clamp_cnt = (sprite_cnt > MAX_CNT) ? MAX_CNT : sprite_cnt;

  always_comb begin
    state_n    = state;
    load_line  = 1'b0;
    load_trans = 1'b0;
    load_fill  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (clamp_cnt == 4'd0) begin
            state_n   = S_FILL;
            load_fill = 1'b1;
          end else begin
            state_n = S_READ;
          end
        end
      end
      S_READ: begin
        if (rd_cnt == 3'd4) state_n = S_CALC;
      end
      S_CALC: begin
        if (in_range) begin
          state_n = S_WAIT;
        end else begin
          state_n    = S_WRITE;
          load_trans = 1'b1;
        end
      end
      S_WAIT: begin
        if (wait_cnt == LAT_LAST) begin
          state_n   = S_WRITE;
          load_line = 1'b1;
        end
      end
      S_WRITE: begin
        if (slot_nxt < count_q) begin
          state_n = S_READ;
        end else if (count_q < MAX_CNT) begin
          state_n   = S_FILL;
          load_fill = 1'b1;
        end else begin
          state_n = S_FIN;
        end
      end
      S_FILL: begin
        if (slot_cnt == 3'd7) state_n = S_FIN;
      end
      S_FIN: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q   <= 8'd0;
      count_q  <= 4'd0;
      slot_cnt <= 3'd0;
      rd_cnt   <= 3'd0;
      wait_cnt <= 4'd0;
      y_q      <= 8'd0;
      tile_q   <= 8'd0;
      attr_q   <= 8'd0;
      x_q      <= 8'd0;
      tile_num <= 8'd0;
      yoffset  <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            scan_q   <= scanline;
            count_q  <= clamp_cnt;
            slot_cnt <= 3'd0;
          end
        end
        S_READ: begin
          // Data for the address issued last cycle arrives now.
          case (rd_cnt)
            3'd1:    y_q    <= oam_data;
            3'd2:    tile_q <= oam_data;
            3'd3:    attr_q <= oam_data;
            3'd4:    x_q    <= oam_data;
            default: ;
          endcase
          rd_cnt <= (rd_cnt == 3'd4) ? 3'd0 : rd_cnt + 3'd1;
        end
        S_CALC: begin
          if (in_range) begin
            tile_num <= tile_q;
            yoffset  <= row;
            wait_cnt <= 4'd0;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 4'd1;
        end
        S_WRITE, S_FILL: begin
          slot_cnt <= slot_cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Slot payload is latched on the edge entering WRITE/FILL so it is stable
  // for the whole strobe cycle; FILL reuses the same empty payload throughout.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_lo   <= 8'd0;
      slot_hi   <= 8'd0;
      slot_attr <= 8'd0;
      slot_x    <= 8'd0;
    end else if (load_line) begin
      slot_lo   <= attr_q[6] ? bit_rev(line0) : line0;
      slot_hi   <= attr_q[6] ? bit_rev(line1) : line1;
      slot_attr <= attr_q;
      slot_x    <= x_q;
    end else if (load_trans) begin
      slot_lo   <= 8'd0;
      slot_hi   <= 8'd0;
      slot_attr <= attr_q;
      slot_x    <= x_q;
    end else if (load_fill) begin
      slot_lo   <= 8'd0;
      slot_hi   <= 8'd0;
      slot_attr <= 8'd0;
      slot_x    <= 8'hFF;
    end
  end

  assign oam_addr  = (state == S_READ) ? {slot_cnt, rd_cnt[1:0]} : 5'd0;
  assign slot_we   = (state == S_WRITE) || (state == S_FILL);
  assign slot_idx  = slot_cnt;
  assign busy      = (state != S_IDLE) && (state != S_FIN);
  assign done      = (state == S_FIN);
  assign state_dbg = state;

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Bench for sprite_line_fetch: OAM and pattern-table models around the DUT, a
// per-line reference built from the sprite rules, and a strobe-by-strobe scoreboard.
module tb_sprite_line_fetch;

  localparam int EW = 63;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] scanline;
  logic [3:0] sprite_cnt;
  logic [4:0] oam_addr;
  logic [7:0] oam_data;
  logic [7:0] tile_num;
  logic [2:0] yoffset;
  logic [7:0] line0;
  logic [7:0] line1;
  logic       slot_we;
  logic [2:0] slot_idx;
  logic [7:0] slot_lo;
  logic [7:0] slot_hi;
  logic [7:0] slot_attr;
  logic [7:0] slot_x;
  logic       busy;
  logic       done;
  logic [2:0] state_dbg;

  sprite_line_fetch #(.FETCH_LAT(2), .NUM_SLOTS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .scanline(scanline),
    .sprite_cnt(sprite_cnt), .oam_addr(oam_addr), .oam_data(oam_data),
    .tile_num(tile_num), .yoffset(yoffset), .line0(line0), .line1(line1),
    .slot_we(slot_we), .slot_idx(slot_idx), .slot_lo(slot_lo),
    .slot_hi(slot_hi), .slot_attr(slot_attr), .slot_x(slot_x),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- environment models ----------------
  logic [7:0]  oam_mem [32];
  logic        force_pat = 1'b0;
  logic [7:0]  force_lo = 8'd0;
  logic [7:0]  force_hi = 8'd0;
  logic [10:0] pt_addr;

  function automatic logic [7:0] pat_lo(input logic [7:0] t, input logic [2:0] r);
    if (force_pat) return force_lo;
    return (t * 8'd7) + ({5'd0, r} * 8'd29) + 8'h13;
  endfunction

  function automatic logic [7:0] pat_hi(input logic [7:0] t, input logic [2:0] r);
    if (force_pat) return force_hi;
    return t ^ {r, r, r[1:0]} ^ 8'hA5;
  endfunction

  function automatic logic [7:0] rev_bits(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  always @(posedge clk) oam_data <= oam_mem[oam_addr];

  // BRAM address register on posedge, output register on negedge: two edges of latency.
  always @(posedge clk) pt_addr <= {tile_num, yoffset};
  always @(negedge clk) begin
    line0 <= pat_lo(pt_addr[10:3], pt_addr[2:0]);
    line1 <= pat_hi(pt_addr[10:3], pt_addr[2:0]);
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] e;
  int            start_cyc = 0;
  int            exp_done_rel = 0;
  bit            done_expected = 1'b0;
  int            done_seen = 0;
  int            rel;
  logic [7:0]    tn_p1, tn_p2;
  logic [2:0]    yo_p1, yo_p2;

  always @(negedge clk) begin
    rel = cyc - start_cyc;
    if (slot_we && done) check("we_done_overlap", 32'd1, 32'd0);
    if (slot_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("we_cycle", rel, 32'(e[62:47]));
        check("slot_idx", 32'(slot_idx), 32'(e[34:32]));
        check("slot_lo", 32'(slot_lo), 32'(e[31:24]));
        check("slot_hi", 32'(slot_hi), 32'(e[23:16]));
        check("slot_attr", 32'(slot_attr), 32'(e[15:8]));
        check("slot_x", 32'(slot_x), 32'(e[7:0]));
        check("busy_at_we", 32'(busy), 32'd1);
        if (e[46]) begin
          check("tile_num_wait1", 32'(tn_p2), 32'(e[45:38]));
          check("tile_num_wait2", 32'(tn_p1), 32'(e[45:38]));
          check("yoffset_wait1", 32'(yo_p2), 32'(e[37:35]));
          check("yoffset_wait2", 32'(yo_p1), 32'(e[37:35]));
        end
      end
    end
    if (done === 1'b1) begin
      done_seen++;
      if (done_expected) check("done_cycle", rel, exp_done_rel);
      else check("unexpected_done", 32'd1, 32'd0);
      check("busy_at_done", 32'(busy), 32'd0);
    end
    tn_p2 = tn_p1;
    tn_p1 = tile_num;
    yo_p2 = yo_p1;
    yo_p1 = yoffset;
  end

  // ---------------- drivers ----------------
  task automatic set_sprite(input int s, input logic [7:0] y, input logic [7:0] t,
                            input logic [7:0] a, input logic [7:0] x);
    oam_mem[s*4]     = y;
    oam_mem[s*4 + 1] = t;
    oam_mem[s*4 + 2] = a;
    oam_mem[s*4 + 3] = x;
  endtask

  task automatic fill_random(input logic [7:0] scan, input int pct_in);
    for (int s = 0; s < 8; s++) begin
      logic [7:0] y;
      if ($urandom_range(0, 99) < pct_in) y = scan - 8'($urandom_range(0, 7));
      else y = 8'($urandom);
      set_sprite(s, y, 8'($urandom), 8'($urandom), 8'($urandom));
    end
  endtask

  // Builds the expected strobes for one line from the sprite rules, then runs it.
  task automatic run_line(input logic [7:0] scan, input int cnt,
                          input int restart_at, input int rst_at);
    int n;
    int t;
    int done_before;
    n = (cnt > 8) ? 8 : cnt;
    t = 0;
    for (int s = 0; s < 8; s++) begin
      logic [7:0] y, tl, at, x, lo, hi, d;
      logic [2:0] r;
      logic       fetch;
      r = 3'd0;
      fetch = 1'b0;
      tl = 8'd0;
      if (s < n) begin
        y  = oam_mem[s*4];
        tl = oam_mem[s*4 + 1];
        at = oam_mem[s*4 + 2];
        x  = oam_mem[s*4 + 3];
        d  = scan - y;
        if (d < 8) begin
          r  = at[7] ? 3'(7 - int'(d)) : d[2:0];
          lo = pat_lo(tl, r);
          hi = pat_hi(tl, r);
          if (at[6]) begin
            lo = rev_bits(lo);
            hi = rev_bits(hi);
          end
          fetch = 1'b1;
          t += 9;
        end else begin
          lo = 8'd0;
          hi = 8'd0;
          t += 7;
        end
      end else begin
        lo = 8'd0;
        hi = 8'd0;
        at = 8'd0;
        x  = 8'hFF;
        t += 1;
      end
      if (rst_at == 0 || t <= rst_at)
        exp_q.push_back({16'(t), fetch, tl, r, 3'(s), lo, hi, at, x});
    end
    exp_done_rel  = t + 1;
    done_expected = (rst_at == 0);

    @(negedge clk);
    start_cyc   = cyc;
    done_before = done_seen;
    scanline    = scan;
    sprite_cnt  = 4'(cnt);
    start       = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start      = (k == restart_at);
      scanline   = 8'($urandom);
      sprite_cnt = 4'($urandom);
      if (rst_at != 0) begin
        if (k == rst_at) rst = 1'b1;
        if (k == rst_at + 1) begin
          check("busy_after_rst", 32'(busy), 32'd0);
          check("we_after_rst", 32'(slot_we), 32'd0);
          rst = 1'b0;
        end
        if (k == rst_at + 30) break;
      end else if (done_seen != done_before && k >= exp_done_rel + 3) begin
        break;
      end
    end
    start = 1'b0;
    check("writes_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    check("done_count", 32'(done_seen - done_before), done_expected ? 32'd1 : 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    scanline   = 8'd0;
    sprite_cnt = 4'd0;
    for (int i = 0; i < 32; i++) oam_mem[i] = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_oam_addr", 32'(oam_addr), 32'd0);
    check("rst_tile_num", 32'(tile_num), 32'd0);
    check("rst_yoffset", 32'(yoffset), 32'd0);
    check("rst_slot_we", 32'(slot_we), 32'd0);
    check("rst_slot_idx", 32'(slot_idx), 32'd0);
    check("rst_slot_lo", 32'(slot_lo), 32'd0);
    check("rst_slot_hi", 32'(slot_hi), 32'd0);
    check("rst_slot_attr", 32'(slot_attr), 32'd0);
    check("rst_slot_x", 32'(slot_x), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    // Empty line: eight fill strobes only.
    run_line(8'd50, 0, 0, 0);

    // Single sprite, no flips.
    set_sprite(0, 8'd10, 8'h21, 8'h00, 8'd40);
    run_line(8'd13, 1, 0, 0);

    // Both flips on a forced pattern.
    force_pat = 1'b1;
    force_lo  = 8'h01;
    force_hi  = 8'h80;
    set_sprite(0, 8'd10, 8'h21, 8'hC0, 8'd40);
    run_line(8'd13, 1, 0, 0);
    force_pat = 1'b0;

    // Out-of-range: wrapped, just past the bottom, and the last in-range row.
    set_sprite(0, 8'd200, 8'h33, 8'h15, 8'd77);
    run_line(8'd5, 1, 0, 0);
    set_sprite(0, 8'd5, 8'h34, 8'h2A, 8'd99);
    run_line(8'd13, 1, 0, 0);
    set_sprite(0, 8'd6, 8'h35, 8'h83, 8'd12);
    run_line(8'd13, 1, 0, 0);

    // Count clamps at 8, with an ignored start mid-fetch.
    fill_random(8'd120, 100);
    run_line(8'd120, 12, 20, 0);

    // Reset during the first WAIT cycle of slot 3, then a clean line.
    fill_random(8'd77, 100);
    run_line(8'd77, 5, 0, 34);
    fill_random(8'd78, 100);
    run_line(8'd78, 5, 0, 0);

    for (int n = 0; n < 25; n++) begin
      logic [7:0] scan;
      int         restart;
      scan = 8'($urandom);
      fill_random(scan, 65);
      restart = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 8) : 0;
      run_line(scan, $urandom_range(0, 15), restart, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
